// File: rtl/steering_pkg.sv
// ---------------------------------------------------------------------------
// steering_pkg
//   Constants shared by the swerve steering rotation logic: FSM state
//   encoding, angle/duty widths and motor direction encoding.
// ---------------------------------------------------------------------------
package steering_pkg;

   localparam int ANGLE_W = 12;
   localparam int DUTY_W  = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_REQUEST = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_UPDATE  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;
   localparam logic [2:0] ST_FAULT   = 3'd5;

   localparam logic DIR_CCW = 1'b1;
   localparam logic DIR_CW  = 1'b0;

endpackage

// File: rtl/duty_ramp.sv
// ---------------------------------------------------------------------------
// duty_ramp
//   Combinational next-duty selection applied on each accepted calculator
//   result that is outside the stop tolerance.
//   Priority: brake on direction change while moving, fixed slow duty near
//   target, otherwise ramp up by RAMP_STEP with saturation at DUTY_MAX.
// Ports
//   delta_i      latched shortest distance to target
//   dir_i        latched shortest direction
//   duty_i       current duty
//   motor_dir_i  current motor direction
//   duty_o       next duty
//   motor_en_o   next motor enable
//   motor_dir_o  next motor direction
// ---------------------------------------------------------------------------
module duty_ramp
   import steering_pkg::*;
#(
   parameter logic [ANGLE_W-1:0] SLOW_ZONE = 12'd256,
   parameter logic [DUTY_W-1:0]  DUTY_MIN  = 8'd32,
   parameter logic [DUTY_W-1:0]  DUTY_MAX  = 8'd255,
   parameter logic [DUTY_W-1:0]  RAMP_STEP = 8'd8
) (
   input  logic [ANGLE_W-1:0] delta_i,
   input  logic               dir_i,
   input  logic [DUTY_W-1:0]  duty_i,
   input  logic               motor_dir_i,
   output logic [DUTY_W-1:0]  duty_o,
   output logic               motor_en_o,
   output logic               motor_dir_o
);

   // One extra bit so the ramp add cannot wrap before saturation.
   logic [DUTY_W:0] sum;

   always_comb begin
      sum         = {1'b0, duty_i} + {1'b0, RAMP_STEP};
      duty_o      = duty_i;
      motor_en_o  = 1'b1;
      motor_dir_o = dir_i;
      if ((dir_i != motor_dir_i) && (duty_i != '0)) begin
         // Brake step: stop first, the next result adopts the new direction.
         duty_o      = '0;
         motor_en_o  = 1'b0;
         motor_dir_o = motor_dir_i;
      end else if (delta_i <= SLOW_ZONE) begin
         duty_o = DUTY_MIN;
      end else if (sum > {1'b0, DUTY_MAX}) begin
         duty_o = DUTY_MAX;
      end else begin
         duty_o = sum[DUTY_W-1:0];
      end
   end

endmodule

// File: rtl/rotation_controller.sv
// ---------------------------------------------------------------------------
// rotation_controller
//   Closed-loop initiator for the shortest-path delta calculator. Requests a
//   calculation, waits for the result (with timeout), and turns each result
//   into motor enable / direction / PWM duty until the target is within
//   tolerance.
//   Optional build macro ROTATION_STALL_DETECT_EN adds stall detection:
//   consecutive driven results whose delta does not shrink raise FAULT.
// Ports
//   clock, reset_n   clock, asynchronous active-low reset
//   start            begin a rotation (accepted in IDLE/DONE/FAULT)
//   abort            stop the motor and return to IDLE from any state
//   enable_calc      one-cycle request to the calculator
//   dir_shortest     calculator direction result (1 = CCW, 0 = CW)
//   delta_angle      calculator shortest distance to target
//   calc_updated     one-cycle valid for the calculator result
//   motor_en         motor enable
//   motor_dir        motor direction (same encoding as dir_shortest)
//   duty             PWM duty
//   rotation_done    held high in DONE
//   rotation_fault   held high in FAULT
// ---------------------------------------------------------------------------
module rotation_controller
   import steering_pkg::*;
#(
   parameter logic [ANGLE_W-1:0] TOLERANCE    = 12'd8,
   parameter logic [ANGLE_W-1:0] SLOW_ZONE    = 12'd256,
   parameter logic [DUTY_W-1:0]  DUTY_MIN     = 8'd32,
   parameter logic [DUTY_W-1:0]  DUTY_MAX     = 8'd255,
   parameter logic [DUTY_W-1:0]  RAMP_STEP    = 8'd8,
   parameter logic [15:0]        CALC_TIMEOUT = 16'd1000
`ifdef ROTATION_STALL_DETECT_EN
   ,
   parameter logic [3:0]         STALL_LIMIT  = 4'd8
`endif
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic               enable_calc,
   input  logic               dir_shortest,
   input  logic [ANGLE_W-1:0] delta_angle,
   input  logic               calc_updated,
   output logic               motor_en,
   output logic               motor_dir,
   output logic [DUTY_W-1:0]  duty,
   output logic               rotation_done,
   output logic               rotation_fault
);

   logic [2:0]         state_q, state_d;
   logic [15:0]        wait_cnt_q, wait_cnt_d;
   logic [ANGLE_W-1:0] delta_q, delta_d;
   logic               dir_q, dir_d;

   logic               ecalc_q, ecalc_d;
   logic               en_q, en_d;
   logic               mdir_q, mdir_d;
   logic [DUTY_W-1:0]  duty_q, duty_d;
   logic               done_q, done_d;
   logic               fault_q, fault_d;

   logic [DUTY_W-1:0]  ramp_duty;
   logic               ramp_en;
   logic               ramp_dir;
   logic               stall_hit;
   logic               start_ok;

   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_FAULT));

   duty_ramp #(
      .SLOW_ZONE (SLOW_ZONE),
      .DUTY_MIN  (DUTY_MIN),
      .DUTY_MAX  (DUTY_MAX),
      .RAMP_STEP (RAMP_STEP)
   ) u_ramp (
      .delta_i     (delta_q),
      .dir_i       (dir_q),
      .duty_i      (duty_q),
      .motor_dir_i (mdir_q),
      .duty_o      (ramp_duty),
      .motor_en_o  (ramp_en),
      .motor_dir_o (ramp_dir)
   );

`ifdef ROTATION_STALL_DETECT_EN
   logic [3:0]         stall_cnt_q, stall_cnt_d;
   logic [ANGLE_W-1:0] prev_delta_q, prev_delta_d;

   // A result that drives the motor but does not bring the target closer
   // counts toward a stall; any other result restarts the count.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      prev_delta_d = prev_delta_q;
      if (abort || start_ok) begin
         stall_cnt_d  = '0;
         prev_delta_d = '0;
      end else if (state_q == ST_UPDATE) begin
         prev_delta_d = delta_q;
         if ((delta_q > TOLERANCE) && ramp_en && (delta_q >= prev_delta_q))
            stall_cnt_d = stall_cnt_q + 4'd1;
         else
            stall_cnt_d = '0;
      end
   end

   assign stall_hit = (state_q == ST_UPDATE) && (stall_cnt_d >= STALL_LIMIT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q  <= '0;
         prev_delta_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         prev_delta_q <= prev_delta_d;
      end
   end
`else
   assign stall_hit = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         delta_q    <= '0;
         dir_q      <= 1'b0;
         ecalc_q    <= 1'b0;
         en_q       <= 1'b0;
         mdir_q     <= 1'b0;
         duty_q     <= '0;
         done_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         delta_q    <= delta_d;
         dir_q      <= dir_d;
         ecalc_q    <= ecalc_d;
         en_q       <= en_d;
         mdir_q     <= mdir_d;
         duty_q     <= duty_d;
         done_q     <= done_d;
         fault_q    <= fault_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      delta_d    = delta_q;
      dir_d      = dir_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_d = ST_REQUEST;
            ST_REQUEST: begin
               wait_cnt_d = '0;
               state_d    = ST_WAIT;
            end
            ST_WAIT: begin
               // A result arriving on the timeout edge is still accepted.
               if (calc_updated) begin
                  delta_d = delta_angle;
                  dir_d   = dir_shortest;
                  state_d = ST_UPDATE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
                  if (wait_cnt_d >= CALC_TIMEOUT) state_d = ST_FAULT;
               end
            end
            ST_UPDATE: begin
               if (delta_q <= TOLERANCE) state_d = ST_DONE;
               else if (stall_hit)       state_d = ST_FAULT;
               else                      state_d = ST_REQUEST;
            end
            ST_DONE, ST_FAULT: if (start) state_d = ST_REQUEST;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output next-values; every output is taken from a flop.
   always_comb begin
      ecalc_d = (state_d == ST_REQUEST);
      done_d  = (state_d == ST_DONE);
      fault_d = (state_d == ST_FAULT);
      en_d    = en_q;
      duty_d  = duty_q;
      mdir_d  = mdir_q;
      if (abort) begin
         en_d   = 1'b0;
         duty_d = '0;
         mdir_d = 1'b0;
      end else if ((state_q == ST_UPDATE) && (state_d == ST_REQUEST)) begin
         en_d   = ramp_en;
         duty_d = ramp_duty;
         mdir_d = ramp_dir;
      end else if ((state_d == ST_DONE) || (state_d == ST_FAULT)) begin
         en_d   = 1'b0;
         duty_d = '0;
      end
   end

   assign enable_calc    = ecalc_q;
   assign motor_en       = en_q;
   assign motor_dir      = mdir_q;
   assign duty           = duty_q;
   assign rotation_done  = done_q;
   assign rotation_fault = fault_q;

endmodule
